// File: rtl/bpm_beat_generator.sv
// ============================================================================
// Module   : bpm_beat_generator
// Purpose  : Turns a BPM estimate into a beat-synchronous pulse train, with a
//            sequential restoring divider and optional onset phase resync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpm_beat_generator #(
    parameter int SAMPLE_RATE   = 8000,
    parameter int MIN_BPM       = 40,
    parameter int MAX_BPM       = 200,
    parameter int DIV_W         = 20,
    parameter int PERIOD_W      = 16,
    parameter int BEATS_PER_BAR = 4,
    parameter int RESYNC_EN     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sample_tick,
    input  logic [15:0]                      BPM_estimate,
    input  logic                             bpm_valid,
    input  logic                             onset,
    output logic                             beat_pulse,
    output logic [$clog2(BEATS_PER_BAR)-1:0] beat_count,
    output logic [PERIOD_W-1:0]              period_samples,
    output logic                             locked,
    output logic                             busy
);

    localparam int                          c_CNT_W    = $clog2(DIV_W);
    localparam int                          c_BC_W     = $clog2(BEATS_PER_BAR);
    localparam logic [DIV_W-1:0]            c_DIVIDEND = DIV_W'(60 * SAMPLE_RATE);
    localparam logic [15:0]                 c_MIN_BPM  = 16'(MIN_BPM);
    localparam logic [15:0]                 c_MAX_BPM  = 16'(MAX_BPM);
    localparam logic [c_CNT_W-1:0]          c_LAST_CNT = c_CNT_W'(DIV_W - 1);
    localparam logic [c_BC_W-1:0]           c_LAST_BC  = c_BC_W'(BEATS_PER_BAR - 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_DIVIDE = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [15:0]        r_divisor;
    logic [15:0]        r_rem;
    logic [DIV_W-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_phase;

    logic               w_start;
    logic               w_last;
    logic [16:0]        w_shift;
    logic               w_ge;
    logic [15:0]        w_rem_next;
    logic [DIV_W-1:0]   w_quo_next;
    logic               w_onset;
    logic               w_wrap;
    logic               w_late;
    logic               w_fire;

    assign w_start = bpm_valid && (r_state == c_IDLE) &&
                     (BPM_estimate >= c_MIN_BPM) && (BPM_estimate <= c_MAX_BPM);
    assign w_last  = (r_state == c_DIVIDE) && (r_cnt == c_LAST_CNT);

    // Remainder stays below the 16-bit divisor, so a 16-bit subtract suffices.
    assign w_shift    = {r_rem, r_quo[DIV_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? (w_shift[15:0] - r_divisor) : w_shift[15:0];
    assign w_quo_next = {r_quo[DIV_W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_DIVIDE;
                end
            end
            c_DIVIDE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_divisor      <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_cnt          <= '0;
            period_samples <= '0;
            locked         <= 1'b0;
        end else if (w_start) begin
            r_divisor <= BPM_estimate;
            r_rem     <= '0;
            r_quo     <= c_DIVIDEND;
            r_cnt     <= '0;
        end else if (r_state == c_DIVIDE) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                period_samples <= w_quo_next[PERIOD_W-1:0];
                locked         <= 1'b1;
            end
        end
    end

    assign w_onset = (RESYNC_EN != 0) && onset;
    assign w_wrap  = sample_tick &&
                     (({1'b0, r_phase} + (PERIOD_W+1)'(1)) >= {1'b0, period_samples});
    assign w_late  = (r_phase >= (period_samples >> 1));
    // An onset overrides the tick; the previous-pulse gate keeps pulses isolated.
    assign w_fire  = !beat_pulse && (w_onset ? w_late : w_wrap);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            beat_pulse <= 1'b0;
            beat_count <= '0;
        end else begin
            beat_pulse <= locked && w_fire;
            if (locked) begin
                if (w_onset) begin
                    r_phase <= '0;
                end else if (sample_tick && !w_wrap) begin
                    r_phase <= r_phase + 1'b1;
                end else if (w_fire) begin
                    r_phase <= '0;
                end
                if (w_fire) begin
                    beat_count <= (beat_count == c_LAST_BC) ? '0 : beat_count + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bpm_beat_generator.sv
// ============================================================================
// Module   : tb_bpm_beat_generator
// Purpose  : Directed bench; one instance at 8 kHz, one at 100 Hz sample rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpm_beat_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] bpm = 16'd0;
    logic        bpm_valid = 1'b0;
    logic        onset = 1'b0;

    logic        a_pulse, a_locked, a_busy;
    logic [1:0]  a_count;
    logic [15:0] a_period;
    logic        b_pulse, b_locked, b_busy;
    logic [1:0]  b_count;
    logic [15:0] b_period;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bpm_beat_generator #(.SAMPLE_RATE(8000)) dut_a (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .BPM_estimate(bpm), .bpm_valid(bpm_valid), .onset(onset),
        .beat_pulse(a_pulse), .beat_count(a_count), .period_samples(a_period),
        .locked(a_locked), .busy(a_busy)
    );

    bpm_beat_generator #(.SAMPLE_RATE(100)) dut_b (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .BPM_estimate(bpm), .bpm_valid(bpm_valid), .onset(onset),
        .beat_pulse(b_pulse), .beat_count(b_count), .period_samples(b_period),
        .locked(b_locked), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bpm(input logic [15:0] v);
        bpm       = v;
        bpm_valid = 1'b1;
        tick();
        bpm_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_vec++;
        if ({a_pulse, a_count, a_period, a_locked, a_busy} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_a: got %h want 0", {a_pulse, a_count, a_period, a_locked, a_busy});
        end
        n_vec++;
        if ({b_pulse, b_count, b_period, b_locked, b_busy} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_b: got %h want 0", {b_pulse, b_count, b_period, b_locked, b_busy});
        end
        reset = 1'b0;
        onset = 1'b1;
        tick();
        onset = 1'b0;
        tick();
        n_vec++;
        if (b_pulse !== 1'b0 || b_count !== 2'd0) begin
            n_err++;
            $display("FAIL onset_unlocked: got pulse=%0b count=%0d want 0/0", b_pulse, b_count);
        end
    endtask

    task automatic test_divide_timing();
        send_bpm(16'd120);
        for (int i = 1; i <= 20; i++) begin
            n_vec++;
            if (a_busy !== 1'b1 || a_locked !== 1'b0 || a_period !== 16'd0) begin
                n_err++;
                $display("FAIL divide_cycle_%0d: got busy=%0b locked=%0b period=%0d want 1/0/0",
                         i, a_busy, a_locked, a_period);
            end
            tick();
        end
        n_vec++;
        if (a_busy !== 1'b0 || a_locked !== 1'b1 || a_period !== 16'd4000) begin
            n_err++;
            $display("FAIL divide_done_120: got busy=%0b locked=%0b period=%0d want 0/1/4000",
                     a_busy, a_locked, a_period);
        end
        n_vec++;
        if (b_period !== 16'd50) begin
            n_err++;
            $display("FAIL divide_done_b: got %0d want 50", b_period);
        end
    endtask

    task automatic test_range();
        logic [15:0] bad [3] = '{16'd30, 16'd250, 16'd0};
        for (int k = 0; k < 3; k++) begin
            send_bpm(bad[k]);
            n_vec++;
            if (a_busy !== 1'b0 || a_period !== 16'd4000) begin
                n_err++;
                $display("FAIL range_ignore_%0d: got busy=%0b period=%0d want 0/4000",
                         bad[k], a_busy, a_period);
            end
        end
        send_bpm(16'd40);
        repeat (20) tick();
        n_vec++;
        if (a_period !== 16'd12000) begin
            n_err++;
            $display("FAIL range_min_40: got %0d want 12000", a_period);
        end
        send_bpm(16'd200);
        repeat (20) tick();
        n_vec++;
        if (a_period !== 16'd2400 || b_period !== 16'd30) begin
            n_err++;
            $display("FAIL range_max_200: got %0d/%0d want 2400/30", a_period, b_period);
        end
    endtask

    task automatic test_drop_and_abort();
        send_bpm(16'd120);
        repeat (4) tick();
        send_bpm(16'd60);
        n_vec++;
        if (a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL drop_busy: got %0b want 1", a_busy);
        end
        repeat (15) tick();
        n_vec++;
        if (a_period !== 16'd4000 || a_busy !== 1'b0 || a_locked !== 1'b1) begin
            n_err++;
            $display("FAIL drop_second_bpm: got period=%0d busy=%0b want 4000/0", a_period, a_busy);
        end
        send_bpm(16'd60);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({a_pulse, a_count, a_period, a_locked, a_busy} !== 21'd0) begin
            n_err++;
            $display("FAIL abort_reset: got %h want 0", {a_pulse, a_count, a_period, a_locked, a_busy});
        end
        repeat (25) tick();
        n_vec++;
        if (a_period !== 16'd0 || a_locked !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_write: got period=%0d locked=%0b want 0/0", a_period, a_locked);
        end
    endtask

    task automatic test_beats();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int np = 0;
        send_bpm(16'd120);
        repeat (20) tick();
        n_vec++;
        if (b_period !== 16'd50 || b_locked !== 1'b1) begin
            n_err++;
            $display("FAIL beats_lock: got period=%0d locked=%0b want 50/1", b_period, b_locked);
        end
        sample_tick = 1'b1;
        for (int cyc = 1; cyc <= 250; cyc++) begin
            tick();
            if (b_pulse === 1'b1) begin
                np++;
                n_vec++;
                if (np > 5 || cyc != 50 * np || b_count !== exp_cnt[np-1]) begin
                    n_err++;
                    $display("FAIL beats_pulse_%0d: got cycle=%0d count=%0d want cycle=%0d",
                             np, cyc, b_count, 50 * np);
                end
            end
        end
        sample_tick = 1'b0;
        n_vec++;
        if (np != 5) begin
            n_err++;
            $display("FAIL beats_total: got %0d pulses want 5", np);
        end
    endtask

    task automatic test_resync();
        sample_tick = 1'b1;
        repeat (40) tick();
        sample_tick = 1'b0;
        onset = 1'b1;
        tick();
        onset = 1'b0;
        n_vec++;
        if (b_pulse !== 1'b1 || b_count !== 2'd2) begin
            n_err++;
            $display("FAIL onset_late: got pulse=%0b count=%0d want 1/2", b_pulse, b_count);
        end
        sample_tick = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_vec++;
            if (b_pulse !== (i == 50)) begin
                n_err++;
                $display("FAIL onset_late_phase0_t%0d: got pulse=%0b want %0b", i, b_pulse, i == 50);
            end
        end
        repeat (10) tick();
        sample_tick = 1'b0;
        onset = 1'b1;
        tick();
        onset = 1'b0;
        n_vec++;
        if (b_pulse !== 1'b0 || b_count !== 2'd3) begin
            n_err++;
            $display("FAIL onset_early: got pulse=%0b count=%0d want 0/3", b_pulse, b_count);
        end
        sample_tick = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_vec++;
            if (b_pulse !== (i == 50)) begin
                n_err++;
                $display("FAIL onset_early_phase0_t%0d: got pulse=%0b want %0b", i, b_pulse, i == 50);
            end
        end
        n_vec++;
        if (b_count !== 2'd0) begin
            n_err++;
            $display("FAIL count_wrap: got %0d want 0", b_count);
        end
        repeat (49) tick();
        onset = 1'b1;
        tick();
        onset = 1'b0;
        sample_tick = 1'b0;
        n_vec++;
        if (b_pulse !== 1'b1 || b_count !== 2'd1) begin
            n_err++;
            $display("FAIL onset_wrap: got pulse=%0b count=%0d want 1/1", b_pulse, b_count);
        end
        tick();
        n_vec++;
        if (b_pulse !== 1'b0 || b_count !== 2'd1) begin
            n_err++;
            $display("FAIL onset_wrap_single: got pulse=%0b count=%0d want 0/1", b_pulse, b_count);
        end
        sample_tick = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_vec++;
            if (b_pulse !== (i == 50)) begin
                n_err++;
                $display("FAIL onset_wrap_phase0_t%0d: got pulse=%0b want %0b", i, b_pulse, i == 50);
            end
        end
        sample_tick = 1'b0;
    endtask

    task automatic test_period_change();
        sample_tick = 1'b1;
        repeat (45) tick();
        sample_tick = 1'b0;
        send_bpm(16'd200);
        repeat (20) tick();
        n_vec++;
        if (b_period !== 16'd30 || b_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL newperiod_load: got period=%0d pulse=%0b want 30/0", b_period, b_pulse);
        end
        sample_tick = 1'b1;
        tick();
        n_vec++;
        if (b_pulse !== 1'b1 || b_count !== 2'd3) begin
            n_err++;
            $display("FAIL newperiod_fire: got pulse=%0b count=%0d want 1/3", b_pulse, b_count);
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_vec++;
            if (b_pulse !== (i == 30)) begin
                n_err++;
                $display("FAIL newperiod_t%0d: got pulse=%0b want %0b", i, b_pulse, i == 30);
            end
        end
        sample_tick = 1'b0;
        n_vec++;
        if (b_count !== 2'd0) begin
            n_err++;
            $display("FAIL newperiod_count: got %0d want 0", b_count);
        end
    endtask

    initial begin
        test_reset();
        test_divide_timing();
        test_range();
        test_drop_and_abort();
        test_beats();
        test_resync();
        test_period_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
